// File: rtl/color_batch_fifo.sv
// Gathers multi-channel colour samples into fixed-size batches held in a ring of
// batch slots; full or flushed batches are presented on a valid/ready output.
module color_batch_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int BATCH_SIZE = 8,
  parameter int NUM_SLOTS  = 2,
  localparam int SW = CHANNELS * DATA_WIDTH,
  localparam int LW = $clog2(BATCH_SIZE + 1),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                     I_rgb_clk,
  input  logic                     I_rst,
  input  logic [SW-1:0]            I_color,
  input  logic                     I_color_valid,
  output logic                     O_color_ready,
  input  logic                     I_flush,
  output logic                     O_batch_valid,
  input  logic                     I_batch_ready,
  output logic [SW*BATCH_SIZE-1:0] O_batch_color,
  output logic [LW-1:0]            O_batch_len,
  output logic [CW-1:0]            O_level,
  output logic                     O_overflow
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int IW = $clog2(BATCH_SIZE);

  logic [SW-1:0] mem_q [NUM_SLOTS][BATCH_SIZE];
  logic [SW-1:0] mem_d [NUM_SLOTS][BATCH_SIZE];
  logic [LW-1:0] len_q [NUM_SLOTS];
  logic [LW-1:0] len_d [NUM_SLOTS];
  logic [PW-1:0] wr_slot_q, wr_slot_d;
  logic [PW-1:0] rd_slot_q, rd_slot_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic          wr_en_s;
  logic          pop_s;
  logic          commit_s;
  logic [LW-1:0] fill_s;

  assign O_color_ready = (level_q != CW'(NUM_SLOTS));
  assign O_batch_valid = (level_q != {CW{1'b0}});
  assign O_level       = level_q;
  assign O_overflow    = overflow_q;

  assign wr_en_s  = I_color_valid && O_color_ready;
  assign pop_s    = O_batch_valid && I_batch_ready;
  // Fill count includes a write landing this cycle, so a flush alongside the
  // final sample commits that single full batch exactly once.
  assign fill_s   = LW'(wr_idx_q) + LW'(wr_en_s);
  assign commit_s = (wr_en_s && (wr_idx_q == IW'(BATCH_SIZE - 1)))
                    || (I_flush && (fill_s != {LW{1'b0}}));

  // Next-state computation for pointers, level, slot storage and overflow
  always_comb begin
    mem_d      = mem_q;
    len_d      = len_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = overflow_q;

    if (wr_en_s) begin
      mem_d[wr_slot_q][wr_idx_q] = I_color;
    end else begin
      overflow_d = overflow_q | I_color_valid;
    end

    if (commit_s) begin
      len_d[wr_slot_q] = fill_s;
      wr_slot_d        = wr_slot_q + PW'(1);
      wr_idx_d         = {IW{1'b0}};
    end else if (wr_en_s) begin
      wr_idx_d = wr_idx_q + IW'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (pop_s) begin
      rd_slot_d = rd_slot_q + PW'(1);
    end else begin
      rd_slot_d = rd_slot_q;
    end

    level_d = level_q + CW'(commit_s) - CW'(pop_s);
  end

  // State registers with synchronous reset
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      mem_q      <= '{default: '0};
      len_q      <= '{default: '0};
      wr_slot_q  <= {PW{1'b0}};
      rd_slot_q  <= {PW{1'b0}};
      wr_idx_q   <= {IW{1'b0}};
      level_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      len_q      <= len_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      wr_idx_q   <= wr_idx_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Output view of the head slot; positions past its length read as zero
  always_comb begin
    O_batch_color = {(SW*BATCH_SIZE){1'b0}};
    if (O_batch_valid) begin
      O_batch_len = len_q[rd_slot_q];
    end else begin
      O_batch_len = {LW{1'b0}};
    end
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (O_batch_valid && (LW'(i) < len_q[rd_slot_q])) begin
        O_batch_color[i*SW +: SW] = mem_q[rd_slot_q][i];
      end else begin
        O_batch_color[i*SW +: SW] = {SW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_color_batch_fifo.sv
// Randomised and directed bench for color_batch_fifo, checked against a
// queue-of-batches reference model.
module tb_color_batch_fifo;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int BS = 8;
  localparam int NS = 2;
  localparam int SW = CH * DW;
  localparam int LW = $clog2(BS + 1);
  localparam int CW = $clog2(NS + 1);

  typedef logic [SW*BS-1:0] batch_t;

  logic              I_rgb_clk = 1'b0;
  logic              I_rst = 1'b1;
  logic [SW-1:0]     I_color = '0;
  logic              I_color_valid = 1'b0;
  logic              O_color_ready;
  logic              I_flush = 1'b0;
  logic              O_batch_valid;
  logic              I_batch_ready = 1'b0;
  logic [SW*BS-1:0]  O_batch_color;
  logic [LW-1:0]     O_batch_len;
  logic [CW-1:0]     O_level;
  logic              O_overflow;

  color_batch_fifo #(.DATA_WIDTH(DW), .CHANNELS(CH), .BATCH_SIZE(BS), .NUM_SLOTS(NS)) dut (
    .I_rgb_clk(I_rgb_clk), .I_rst(I_rst), .I_color(I_color),
    .I_color_valid(I_color_valid), .O_color_ready(O_color_ready),
    .I_flush(I_flush), .O_batch_valid(O_batch_valid), .I_batch_ready(I_batch_ready),
    .O_batch_color(O_batch_color), .O_batch_len(O_batch_len),
    .O_level(O_level), .O_overflow(O_overflow)
  );

  always #5 I_rgb_clk = ~I_rgb_clk;

  int total = 0;
  int bad = 0;

  batch_t mq[$];
  int     ml[$];
  batch_t cur;
  int     cnt;
  bit     movf;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit ev;
    ev = (mq.size() != 0);
    check_eq("valid", 256'(O_batch_valid), 256'(ev));
    check_eq("ready", 256'(O_color_ready), 256'(mq.size() != NS));
    check_eq("level", 256'(O_level), 256'(mq.size()));
    check_eq("overflow", 256'(O_overflow), 256'(movf));
    check_eq("len", 256'(O_batch_len), ev ? 256'(ml[0]) : 256'(0));
    check_eq("color", 256'(O_batch_color), ev ? 256'(mq[0]) : 256'(0));
  endtask

  // One clock: drive inputs, advance the model on the edge, check after it.
  task automatic step(input bit rst, input bit v, input logic [SW-1:0] c,
                      input bit fl, input bit rd);
    bit rdy;
    bit pop;
    I_rst = rst; I_color_valid = v; I_color = c; I_flush = fl; I_batch_ready = rd;
    @(posedge I_rgb_clk);
    if (rst) begin
      mq.delete(); ml.delete(); cur = '0; cnt = 0; movf = 1'b0;
    end else begin
      rdy = (mq.size() < NS);
      pop = (mq.size() > 0) && rd;
      if (v && rdy) begin
        cur[cnt*SW +: SW] = c;
        cnt++;
      end else if (v) begin
        movf = 1'b1;
      end
      if (pop) begin
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (cnt == BS || (fl && cnt > 0)) begin
        mq.push_back(cur);
        ml.push_back(cnt);
        cur = '0;
        cnt = 0;
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    cur = '0; cnt = 0; movf = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Eight consecutive samples with the consumer ready
    for (int i = 0; i < 8; i++) step(0, 1, 24'h010203 + 24'(i) * 24'h010101, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Partial batch closed by flush
    step(0, 1, 24'hAA0000, 0, 0);
    step(0, 1, 24'h00BB00, 0, 0);
    step(0, 1, 24'h0000CC, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Sixteen samples under backpressure, then a dropped seventeenth
    for (int i = 0; i < 16; i++) step(0, 1, 24'($urandom), 0, 0);
    step(0, 1, 24'h123456, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Flush with nothing pending, then flush alongside the eighth write
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 1, 24'($urandom), 0, 0);
    step(0, 1, 24'hFEDCBA, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Reset partway through a batch, then a clean batch
    for (int i = 0; i < 5; i++) step(0, 1, 24'($urandom), 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 24'hC00000 + 24'(i), 0, 1);
    step(0, 0, 0, 0, 1);

    // Sustained streaming with continuous pops across many batches
    for (int i = 0; i < 10 * BS; i++) step(0, 1, 24'($urandom), 0, 1);
    step(0, 0, 0, 0, 1);

    // Random traffic with varying consumer duty cycle
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), 24'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
